// File: rtl/vga_bus_timing.sv
// SVGA pixel timing source. Drives the packed VGA bus
// {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb} into the first overlay stage,
// and provides a frame-start pulse plus a free-running frame counter.
module vga_bus_timing #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BACK    = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FRONT   = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BACK    = 23,
    parameter logic        SYNC_POL  = 1'b1,
    parameter logic [11:0] BG_COLOUR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    // {hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}
    output logic [37:0] vga_bus_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    // Totals must stay below 2048 so every counter value fits in 11 bits.
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HSYNC_BEG  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HSYNC_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VSYNC_BEG  = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VSYNC_END  = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic [11:0] rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Next counter values, with all decoded fields derived from them so the
    // registered bus fields always describe the same pixel.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end

        hblnk_d = (hcount_d >= H_ACT);
        vblnk_d = (vcount_d >= V_ACT);
        hsync_d = ((hcount_d >= HSYNC_BEG) && (hcount_d < HSYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= VSYNC_BEG) && (vcount_d < VSYNC_END)) ? SYNC_POL : ~SYNC_POL;
        rgb_d   = (!hblnk_d && !vblnk_d) ? BG_COLOUR : 12'h000;

        // The reset (0,0) state is never reached through here, so it is not a frame start.
        frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
        frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
    end

    // Output and counter registers; all bus fields share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            rgb_q         <= BG_COLOUR;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vga_bus_out = {hcount_q, vcount_q, hsync_q, vsync_q, hblnk_q, vblnk_q, rgb_q};
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_bus_timing.sv
// Bench for vga_bus_timing: one instance with full SVGA timing (line-level behaviour)
// and one with shrunk timing (frame wrap, counter wrap) driven from the same clock/reset.
module tb_vga_bus_timing;

    // Full-size instance timing, non-zero background so rgb gating is visible.
    localparam int unsigned F_HA = 800, F_HF = 40, F_HS = 128, F_HB = 88;
    localparam int unsigned F_VA = 600, F_VF = 1,  F_VS = 4,   F_VB = 23;
    localparam logic        F_POL = 1'b1;
    localparam logic [11:0] F_BG  = 12'h5A3;
    localparam int unsigned F_FRAME = 1056 * 628;

    // Small instance: 32 x 20 totals, negative sync polarity.
    localparam int unsigned S_HA = 16, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int unsigned S_VA = 12, S_VF = 1, S_VS = 4, S_VB = 3;
    localparam logic        S_POL = 1'b0;
    localparam logic [11:0] S_BG  = 12'hF0F;
    localparam int unsigned S_FRAME = 32 * 20;

    typedef struct {
        logic [37:0] bus;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [37:0] bus_f, bus_s;
    logic        fs_f, fs_s;
    logic [15:0] fc_f, fc_s;

    int          n_checks;
    int          n_fail;
    int unsigned cyc;
    logic [15:0] exp_cnt_f, exp_cnt_s;
    exp_t        q_full[$];
    exp_t        q_small[$];
    logic        wrap_seen;

    vga_bus_timing #(
        .H_ACTIVE(F_HA), .H_FRONT(F_HF), .H_SYNC(F_HS), .H_BACK(F_HB),
        .V_ACTIVE(F_VA), .V_FRONT(F_VF), .V_SYNC(F_VS), .V_BACK(F_VB),
        .SYNC_POL(F_POL), .BG_COLOUR(F_BG)
    ) dut_full (
        .clk(clk), .rst(rst), .vga_bus_out(bus_f), .frame_start(fs_f), .frame_cnt(fc_f)
    );

    vga_bus_timing #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(S_POL), .BG_COLOUR(S_BG)
    ) dut_small (
        .clk(clk), .rst(rst), .vga_bus_out(bus_s), .frame_start(fs_s), .frame_cnt(fc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference bus for the k-th edge after reset release, from the flat cycle index.
    function automatic logic [37:0] model_bus(input int unsigned k,
                                              input int unsigned ha, input int unsigned hf,
                                              input int unsigned hs, input int unsigned hb,
                                              input int unsigned va, input int unsigned vf,
                                              input int unsigned vs, input int unsigned vb,
                                              input logic pol, input logic [11:0] bg);
        int unsigned ht, vt, h, v;
        logic        hbl, vbl, hsy, vsy;
        logic [11:0] rgb;
        logic [10:0] h11, v11;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        h   = k % ht;
        v   = (k / ht) % vt;
        hbl = (h >= ha);
        vbl = (v >= va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        rgb = (hbl || vbl) ? 12'h000 : bg;
        h11 = h[10:0];
        v11 = v[10:0];
        return {h11, v11, hsy, vsy, hbl, vbl, rgb};
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expectations for the coming edge, clock once, then pop and compare.
    task automatic step();
        exp_t ef, es, pf, ps;
        int unsigned k;
        k      = cyc + 1;
        ef.bus = model_bus(k, F_HA, F_HF, F_HS, F_HB, F_VA, F_VF, F_VS, F_VB, F_POL, F_BG);
        ef.fs  = (k % F_FRAME) == 0;
        if (ef.fs) exp_cnt_f = exp_cnt_f + 16'd1;
        ef.fc  = exp_cnt_f;
        es.bus = model_bus(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_POL, S_BG);
        es.fs  = (k % S_FRAME) == 0;
        if (es.fs) exp_cnt_s = exp_cnt_s + 16'd1;
        es.fc  = exp_cnt_s;
        q_full.push_back(ef);
        q_small.push_back(es);

        @(posedge clk);
        #1;
        cyc = k;
        pf = q_full.pop_front();
        ps = q_small.pop_front();
        check($sformatf("full_bus@%0d", k), bus_f, pf.bus);
        check($sformatf("full_fs@%0d", k), {37'd0, fs_f}, {37'd0, pf.fs});
        check($sformatf("full_fc@%0d", k), {22'd0, fc_f}, {22'd0, pf.fc});
        check($sformatf("small_bus@%0d", k), bus_s, ps.bus);
        check($sformatf("small_fs@%0d", k), {37'd0, fs_s}, {37'd0, ps.fs});
        check($sformatf("small_fc@%0d", k), {22'd0, fc_s}, {22'd0, ps.fc});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_full_bus"}, bus_f, {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A3});
        check({tag, "_small_bus"}, bus_s, {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hF0F});
        check({tag, "_full_fs"}, {37'd0, fs_f}, 38'd0);
        check({tag, "_small_fs"}, {37'd0, fs_s}, 38'd0);
        check({tag, "_full_fc"}, {22'd0, fc_f}, 38'd0);
        check({tag, "_small_fc"}, {22'd0, fc_s}, 38'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        exp_cnt_f = '0;
        exp_cnt_s = '0;
        wrap_seen = 1'b0;

        // Reset held across several edges, then released between edges.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Two full SVGA lines plus wrap; the small instance runs several frames meanwhile.
        repeat (2200) step();

        // Preload the small frame counter to its top value and run past the next frame wrap.
        force dut_small.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_small.frame_cnt_q;
        exp_cnt_s = 16'hFFFF;
        for (int i = 0; i < 700; i++) begin
            step();
            if (fs_s && fc_s == 16'h0000) wrap_seen = 1'b1;
        end
        check("cnt_wrap_pulse", {37'd0, wrap_seen}, 38'd1);

        // Asynchronous reset mid-line / mid-frame, applied between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("async_hold");
        rst       = 1'b0;
        cyc       = 0;
        exp_cnt_f = '0;
        exp_cnt_s = '0;
        q_full.delete();
        q_small.delete();

        // Sequence after release must replay the first scenario from hcount=1.
        repeat (1100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
